// File: rtl/wb_uart_pkg.sv
// Shared definitions for the Wishbone UART: register offsets, STATUS/CTRL bit
// positions, TX/RX state encodings and the minimum bit period.
package wb_uart_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_DIV    = 2'd2,
        REG_CTRL   = 2'd3
    } reg_addr_e;

    localparam int STAT_TX_BUSY      = 0;
    localparam int STAT_TX_EMPTY     = 1;
    localparam int STAT_TX_FULL      = 2;
    localparam int STAT_RX_VALID     = 3;
    localparam int STAT_RX_OVERRUN   = 4;
    localparam int STAT_RX_FRAME_ERR = 5;

    localparam int CTRL_IRQ_TX_EMPTY = 0;
    localparam int CTRL_IRQ_RX_VALID = 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    localparam logic [15:0] DIV_MIN = 16'd4;

    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        return (div < DIV_MIN) ? DIV_MIN : div;
    endfunction

endpackage

// File: rtl/wb_uart_fifo.sv
// Single-clock synchronous FIFO with first-word fall-through read data.
// Pushes into a full FIFO are dropped, even when a pop happens in the same cycle.
module wb_uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/wb_uart.sv
// Wishbone UART with a TX FIFO and a single-byte RX holding register.
// The receive path is only built when the macro WB_UART_RX_EN is defined.
module wb_uart
    import wb_uart_pkg::*;
#(
    parameter int CLK_FREQ      = 25_000_000,
    parameter int BAUDRATE      = 115200,
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] wb_addr_i,
    input  logic [31:0] wb_wdata_i,
    output logic [31:0] wb_rdata_o,
    input  logic        wb_wr_en_i,
    input  logic [3:0]  wb_byte_en_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        ser_tx_o,
    input  logic        ser_rx_i,
    output logic        irq_o
);
    localparam logic [15:0] DIV_RESET = clamp_div(16'(CLK_FREQ / BAUDRATE));

    logic        ack, req, bus_we, irq;
    reg_addr_e   bus_addr;
    logic [15:0] bus_wdata, div_reg;
    logic [1:0]  ctrl;
    logic        wr_data, rd_data, rd_status;
    logic [31:0] status, rdata;

    logic        fifo_empty, fifo_full;
    logic [7:0]  fifo_rdata;
    tx_state_e   tx_state, tx_next;
    logic        tx_load, tx_tick, tx_busy;
    logic [15:0] tx_cnt, tx_div;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;

    logic        rx_valid, rx_overrun, rx_frame_err;
    logic [7:0]  rx_byte;
    logic        unused_bits;

    assign unused_bits = ^{wb_addr_i[31:4], wb_addr_i[1:0], wb_byte_en_i, wb_wdata_i[31:16]};

    // Request is captured one cycle before the ack; all side effects use the captured copy.
    assign req = wb_stb_i & wb_cyc_i & ~ack;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack       <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= REG_DATA;
            bus_wdata <= '0;
        end else begin
            ack <= req;
            if (req) begin
                bus_we    <= wb_wr_en_i;
                bus_addr  <= reg_addr_e'(wb_addr_i[3:2]);
                bus_wdata <= wb_wdata_i[15:0];
            end
        end
    end

    assign wr_data   = ack & bus_we & (bus_addr == REG_DATA);
    assign rd_data   = ack & ~bus_we & (bus_addr == REG_DATA);
    assign rd_status = ack & ~bus_we & (bus_addr == REG_STATUS);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_reg <= DIV_RESET;
            ctrl    <= '0;
            irq     <= 1'b0;
        end else begin
            if (ack && bus_we && bus_addr == REG_DIV)  div_reg <= clamp_div(bus_wdata);
            if (ack && bus_we && bus_addr == REG_CTRL) ctrl    <= bus_wdata[1:0];
            irq <= (ctrl[CTRL_IRQ_TX_EMPTY] & fifo_empty & ~tx_busy) |
                   (ctrl[CTRL_IRQ_RX_VALID] & rx_valid);
        end
    end

    wb_uart_fifo #(.DEPTH(TX_FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (wr_data),
        .wdata (bus_wdata[7:0]),
        .pop   (tx_load),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_tick = (tx_cnt == 16'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tx_state <= TX_IDLE;
        else         tx_state <= tx_next;
    end

    // STOP chains straight into START so queued bytes leave with no idle gap.
    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        case (tx_state)
            TX_IDLE:  if (!fifo_empty) begin tx_next = TX_START; tx_load = 1'b1; end
            TX_START: if (tx_tick) tx_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_tick) begin
                          if (!fifo_empty) begin tx_next = TX_START; tx_load = 1'b1; end
                          else tx_next = TX_IDLE;
                      end
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_busy  = (tx_state != TX_IDLE);
        ser_tx_o = 1'b1;
        case (tx_state)
            TX_START: ser_tx_o = 1'b0;
            TX_DATA:  ser_tx_o = tx_shift[0];
            default:  ser_tx_o = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else if (tx_load) begin
            tx_shift <= fifo_rdata;
            tx_div   <= div_reg;
            tx_cnt   <= div_reg - 16'd1;
            tx_bit   <= '0;
        end else if (tx_state != TX_IDLE) begin
            if (tx_tick) begin
                tx_cnt <= tx_div - 16'd1;
                if (tx_state == TX_DATA) begin
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= tx_bit + 3'd1;
                end
            end else begin
                tx_cnt <= tx_cnt - 16'd1;
            end
        end
    end

`ifdef WB_UART_RX_EN
    rx_state_e   rx_state, rx_next;
    logic [1:0]  rx_sync;
    logic        rx_in, rx_prev, rx_tick, rx_done, rx_ferr, overrun_set;
    logic [15:0] rx_cnt, rx_div;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;

    assign rx_in   = rx_sync[1];
    assign rx_tick = (rx_cnt == 16'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
        end else begin
            rx_sync  <= {rx_sync[0], ser_rx_i};
            rx_prev  <= rx_in;
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_in) rx_next = RX_START;
            RX_START: if (rx_tick) rx_next = rx_in ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_done     = (rx_state == RX_STOP) && rx_tick && rx_in;
        rx_ferr     = (rx_state == RX_STOP) && rx_tick && !rx_in;
        overrun_set = rx_done && rx_valid && !rd_data;
    end

    // While idle the counter is preloaded so the start bit is re-checked at mid-bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_cnt   <= '0;
            rx_div   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else if (rx_state == RX_IDLE) begin
            rx_div <= div_reg;
            rx_cnt <= (div_reg >> 1) - 16'd1;
            rx_bit <= '0;
        end else if (rx_tick) begin
            rx_cnt <= rx_div - 16'd1;
            if (rx_state == RX_DATA) begin
                rx_shift <= {rx_in, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end else begin
            rx_cnt <= rx_cnt - 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_byte      <= '0;
        end else begin
            if (rx_done)      rx_valid <= 1'b1;
            else if (rd_data) rx_valid <= 1'b0;
            if (rx_done && !overrun_set) rx_byte <= rx_shift;
            if (overrun_set)    rx_overrun <= 1'b1;
            else if (rd_status) rx_overrun <= 1'b0;
            if (rx_ferr)        rx_frame_err <= 1'b1;
            else if (rd_status) rx_frame_err <= 1'b0;
        end
    end
`else
    logic unused_rx;
    assign unused_rx    = ^{ser_rx_i, rd_data, rd_status};
    assign rx_valid     = 1'b0;
    assign rx_overrun   = 1'b0;
    assign rx_frame_err = 1'b0;
    assign rx_byte      = '0;
`endif

    always_comb begin
        status                    = '0;
        status[STAT_TX_BUSY]      = tx_busy;
        status[STAT_TX_EMPTY]     = fifo_empty;
        status[STAT_TX_FULL]      = fifo_full;
        status[STAT_RX_VALID]     = rx_valid;
        status[STAT_RX_OVERRUN]   = rx_overrun;
        status[STAT_RX_FRAME_ERR] = rx_frame_err;
    end

    always_comb begin
        rdata = '0;
        if (ack && !bus_we) begin
            case (bus_addr)
                REG_DATA:   rdata = {24'd0, rx_byte};
                REG_STATUS: rdata = status;
                REG_DIV:    rdata = {16'd0, div_reg};
                REG_CTRL:   rdata = {30'd0, ctrl};
                default:    rdata = '0;
            endcase
        end
    end

    assign wb_ack_o   = ack;
    assign wb_rdata_o = rdata;
    assign irq_o      = irq;

endmodule
